spiflash_cache_wb: RTL
======================

Name: spiflash_cache_wb

Overview:
- Direct-mapped, read-only word cache between the CPU instruction/data Wishbone bus and the SPI flash read controller.
- Hits return in 2 cycles and never start a SPI transaction.
- Misses issue one 32-bit Wishbone read downstream, fill the line, then answer the CPU.
- Cuts execute-in-place fetch cost from ~140 SPI clocks to 2 cycles on a hit.

Parameters:
- LINES, 64, number of one-word cache lines; power of two, 2..256.
- ADDR_W, 24, flash byte-address width used for index/tag.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_ni  in  1  synchronous reset, active low
- wb_adr_i  in  32  upstream byte address
- wb_dat_i  in  32  upstream write data (ignored)
- wb_dat_o  out  32  upstream read data
- wb_sel_i  in  4  byte selects (ignored; full words are returned)
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  cycle
- wb_stb_i  in  1  strobe
- wb_ack_o  out  1  one-cycle acknowledge
- m_adr_o  out  32  downstream byte address
- m_cyc_o  out  1  downstream cycle
- m_stb_o  out  1  downstream strobe
- m_we_o  out  1  tied 0
- m_dat_i  in  32  downstream read data
- m_ack_i  in  1  downstream acknowledge
- flush_i  in  1  invalidate all lines (pulse)

Behaviour:
- Reset (wb_rst_ni=0 on a clock edge):
  - wb_ack_o=0, wb_dat_o=0, m_cyc_o=m_stb_o=0, m_adr_o=0.
  - All valid bits cleared; state=IDLE.
  - Reset mid-fill abandons the downstream cycle immediately.
- Request definition: req = wb_cyc_i & wb_stb_i & !wb_ack_o.
- Address split:
  - index = wb_adr_i[2 +: log2(LINES)]
  - tag = wb_adr_i[ADDR_W-1 : 2+log2(LINES)]
  - wb_adr_i[1:0] ignored.
- Storage:
  - data+tag array read synchronously, one port, written on fill.
  - Valid bits are flops so flush clears them in one cycle.
- FSM:
  - IDLE: on req & wb_we_i, ack next cycle with no effect. On req & !wb_we_i, latch address, issue array read, go LOOKUP.
  - LOOKUP: hit = valid[index] & tag match.
    - Hit: wb_dat_o=array data, wb_ack_o=1, go RESP. Hit latency is 2 cycles from the req edge to the ack edge.
    - Miss: m_adr_o = {zeros, adr[ADDR_W-1:2], 2'b00}, m_cyc_o=m_stb_o=1, go FILL.
  - FILL: hold m_cyc_o/m_stb_o until m_ack_i. On m_ack_i:
    - drop m_cyc_o/m_stb_o the same edge;
    - write data+tag into the array; set valid unless a flush occurred during the fill;
    - wb_dat_o=m_dat_i, wb_ack_o=1 (only if wb_cyc_i still high); go RESP.
  - RESP: wb_ack_o returns to 0; go IDLE.
- Ack and strobe rules:
  - wb_ack_o is high for exactly one cycle per request.
  - Downstream strobe never stays high the cycle after m_ack_i; the flash controller requires strobe to drop before it clears its ack.
- Upstream abort: if wb_cyc_i falls during FILL, the downstream read completes and the line is filled, but no upstream ack is issued.
- Data byte order passes through unchanged; the flash controller has already byte-swapped.
- flush_i:
  - In IDLE or LOOKUP, clears valid the same edge; a LOOKUP that edge is treated as a miss.
  - During FILL, clears valid; the in-flight line is not validated.

Optional Feature:
- Macro: SPIFLASH_CACHE_STATS_EN.
- Enabled: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - Free-running, wrap at 2^32, reset to 0.
  - Increment once per read request resolved in LOOKUP.
  - flush_i does not clear them.
- Disabled: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package spiflash_cache_pkg: FSM state enum (IDLE, LOOKUP, FILL, RESP), index/tag width functions from LINES/ADDR_W, downstream address pad constant.
- One sub-module, spiflash_cache_ram: single-port synchronous RAM of {tag,data}, depth LINES, write-enable, registered read.
- Valid flops and FSM stay in the top.

Test Plan:
- Cold read 0x000100 → m_adr_o=0x00000100 once; downstream returns 0xDEADBEEF → wb_dat_o=0xDEADBEEF, single-cycle ack.
- Repeat read 0x000100 → ack 2 cycles after req, m_cyc_o stays 0, data 0xDEADBEEF.
- Alias conflict, LINES=64: read 0x000100 then 0x000200 (same index 0, different tag) → second misses and refills; re-read 0x000100 misses again.
- flush_i pulse, then read 0x000100 → miss. flush_i during FILL → data returned, following read of the same address misses.
- Write request → ack next cycle, no downstream cycle, cache contents unchanged.
- wb_rst_ni low while m_cyc_o high → next cycle m_cyc_o=0, wb_ack_o=0, all subsequent reads miss. With STATS_EN: 3 reads of one address → hit_cnt_o=2, miss_cnt_o=1.

Source files
------------

// File: rtl/spiflash_cache_pkg.sv
// Shared types and sizing helpers for the SPI flash read cache.
package spiflash_cache_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLookup,
        StFill,
        StResp
    } state_e;

    // Low two bits of every downstream byte address: the cache only fetches whole words.
    localparam logic [1:0] WordPad = 2'b00;

    function automatic int unsigned idx_width(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned tag_width(input int unsigned lines,
                                              input int unsigned addr_w);
        return addr_w - 2 - $clog2(lines);
    endfunction

endpackage

// File: rtl/spiflash_cache_ram.sv
// Single-port {tag,data} line store with a registered read port.
module spiflash_cache_ram #(
    parameter int unsigned Depth = 64,
    parameter int unsigned Width = 48
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(Depth)-1:0] addr,
    input  logic [Width-1:0]         wdata,
    output logic [Width-1:0]         rdata
);

    logic [Width-1:0] mem [Depth];

    // Write on fill; read every cycle so a lookup sees the line one cycle after the request.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/spiflash_cache_wb.sv
// Direct-mapped read-only word cache between the CPU Wishbone bus and the SPI flash reader.
// Optional hit/miss counters are built when SPIFLASH_CACHE_STATS_EN is defined.
module spiflash_cache_wb
    import spiflash_cache_pkg::*;
#(
    parameter int unsigned LINES  = 64,
    parameter int unsigned ADDR_W = 24
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic [31:0] m_adr_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
`ifdef SPIFLASH_CACHE_STATS_EN
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o,
`endif
    input  logic        flush_i
);

    localparam int unsigned IdxW  = idx_width(LINES);
    localparam int unsigned TagW  = tag_width(LINES, ADDR_W);
    localparam int unsigned WadrW = ADDR_W - 2;
    localparam int unsigned RamW  = TagW + 32;

    state_e             state_q, state_d;
    logic [WadrW-1:0]   adr_q, adr_d;
    logic               ack_q, ack_d;
    logic [31:0]        dat_q, dat_d;
    logic               mcyc_q, mcyc_d;
    logic [31:0]        madr_q, madr_d;
    logic               flushed_q, flushed_d;
    logic [LINES-1:0]   valid_q;

    logic               req;
    logic               hit;
    logic               fill_done;
    logic [IdxW-1:0]    req_idx;
    logic [IdxW-1:0]    cur_idx;
    logic [TagW-1:0]    cur_tag;
    logic               ram_we;
    logic [IdxW-1:0]    ram_addr;
    logic [RamW-1:0]    ram_wdata;
    logic [RamW-1:0]    ram_rdata;
    logic               unused_bits;

    assign unused_bits = ^{wb_dat_i, wb_sel_i, wb_adr_i[31:ADDR_W], wb_adr_i[1:0]};

    assign req       = wb_cyc_i & wb_stb_i & ~ack_q;
    assign req_idx   = wb_adr_i[2 +: IdxW];
    assign cur_idx   = adr_q[IdxW-1:0];
    assign cur_tag   = adr_q[WadrW-1:IdxW];
    // A flush on the lookup edge forces a miss so no stale line is ever returned.
    assign hit       = valid_q[cur_idx] & (ram_rdata[RamW-1:32] == cur_tag) & ~flush_i;
    assign fill_done = (state_q == StFill) & m_ack_i;

    assign ram_we    = fill_done;
    assign ram_addr  = (state_q == StFill) ? cur_idx : req_idx;
    assign ram_wdata = {cur_tag, m_dat_i};

    spiflash_cache_ram #(
        .Depth (LINES),
        .Width (RamW)
    ) u_ram (
        .clk   (wb_clk_i),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Next-state and registered-output logic of the request FSM.
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        ack_d     = 1'b0;
        dat_d     = dat_q;
        mcyc_d    = mcyc_q;
        madr_d    = madr_q;
        flushed_d = flushed_q | flush_i;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (wb_we_i) begin
                        ack_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        adr_d   = wb_adr_i[ADDR_W-1:2];
                        state_d = StLookup;
                    end
                end
            end
            StLookup: begin
                if (hit) begin
                    ack_d   = 1'b1;
                    dat_d   = ram_rdata[31:0];
                    state_d = StResp;
                end else begin
                    madr_d    = 32'({adr_q, WordPad});
                    mcyc_d    = 1'b1;
                    flushed_d = 1'b0;
                    state_d   = StFill;
                end
            end
            StFill: begin
                if (m_ack_i) begin
                    // Strobe drops on the ack edge; ack upstream only if the CPU still waits.
                    mcyc_d  = 1'b0;
                    dat_d   = m_dat_i;
                    ack_d   = wb_cyc_i;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset abandons any downstream cycle at once.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q   <= StIdle;
            adr_q     <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            mcyc_q    <= 1'b0;
            madr_q    <= '0;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            mcyc_q    <= mcyc_d;
            madr_q    <= madr_d;
            flushed_q <= flushed_d;
        end
    end

    // Valid flops: flush wipes all lines in one edge; a fill overlapped by a flush stays invalid.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (fill_done && !flushed_q) begin
            valid_q[cur_idx] <= 1'b1;
        end
    end

`ifdef SPIFLASH_CACHE_STATS_EN
    // Hit/miss counters, one step per read resolved in lookup; flush leaves them alone.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (state_q == StLookup) begin
            if (hit) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end else begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign m_cyc_o  = mcyc_q;
    assign m_stb_o  = mcyc_q;
    assign m_adr_o  = madr_q;
    assign m_we_o   = 1'b0;

endmodule
